// File: rtl/delay_ctrl_pkg.sv
// Shared types and helpers for the delay_ctrl block.
// Build option: DELAY_CTRL_HOLD_EN adds a hold input to delay_ctrl.
package delay_ctrl_pkg;

    typedef enum logic [1:0] {
        D_IDLE,
        D_FILL,
        D_RUN
    } delay_state_t;

    localparam int MAX_DELAY_DEF = 16;

    function automatic int calc_dw(input int max_delay);
        return $clog2(max_delay + 1);
    endfunction

endpackage

// File: rtl/delay_ctrl_if.sv
// Configuration handshake and bitstream bundle for delay_ctrl.
// Build option: DELAY_CTRL_HOLD_EN (hold stays a plain port on the top).
interface delay_ctrl_if
    import delay_ctrl_pkg::*;
#(
    parameter int MAX_DELAY = MAX_DELAY_DEF,
    parameter int DW        = calc_dw(MAX_DELAY)
) ();

    logic          cfg_valid;
    logic [DW-1:0] cfg_delay;
    logic          cfg_ready;
    logic          cfg_err;
    logic          x;
    logic          y;
    logic          y_valid;
    logic          busy;

    modport master (
        output cfg_valid,
        output cfg_delay,
        output x,
        input  cfg_ready,
        input  cfg_err,
        input  y,
        input  y_valid,
        input  busy
    );

    modport slave (
        input  cfg_valid,
        input  cfg_delay,
        input  x,
        output cfg_ready,
        output cfg_err,
        output y,
        output y_valid,
        output busy
    );

endinterface

// File: rtl/delay_ctrl_tap_shift_reg.sv
// Variable-tap serial shift register; tap_sel=i returns the sample
// taken i+1 shifts ago. Build option DELAY_CTRL_HOLD_EN does not apply here.
module tap_shift_reg
    import delay_ctrl_pkg::*;
#(
    parameter int DEPTH = MAX_DELAY_DEF,
    parameter int TW    = calc_dw(DEPTH)
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          shift_en,
    input  logic          clr,
    input  logic          din,
    input  logic [TW-1:0] tap_sel,
    output logic          tap_out
);

    logic [DEPTH-1:0] sreg_q;
    logic [DEPTH-1:0] sreg_d;
    logic [DEPTH:0]   sreg_ext;

    // Next register contents: clear wins over shift
    always_comb begin
        sreg_ext = {sreg_q, din};
        sreg_d   = sreg_q;
        if (clr) begin
            sreg_d = '0;
        end else if (shift_en) begin
            sreg_d = sreg_ext[DEPTH-1:0];
        end
    end

    // Register storage with asynchronous clear
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sreg_q <= '0;
        end else begin
            sreg_q <= sreg_d;
        end
    end

    // Tap multiplexer; out-of-range selects read as 0
    always_comb begin
        tap_out = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (tap_sel == TW'(i)) begin
                tap_out = sreg_q[i];
            end
        end
    end

endmodule

// File: rtl/delay_ctrl.sv
// Runtime-configurable delay-line controller: FSM, counter, handshake.
// Build option: DELAY_CTRL_HOLD_EN adds a hold input that freezes the datapath.
module delay_ctrl
    import delay_ctrl_pkg::*;
#(
    parameter int MAX_DELAY = MAX_DELAY_DEF
) (
    input logic CLK,
    input logic RST,
`ifdef DELAY_CTRL_HOLD_EN
    input logic hold,
`endif
    delay_ctrl_if.slave bus
);

    localparam int DW = calc_dw(MAX_DELAY);

    delay_state_t  state_q, state_d;
    logic [DW-1:0] delay_q, delay_d;
    logic [DW-1:0] cnt_q, cnt_d;
    logic          cfg_err_q, cfg_err_d;

    logic          hold_w;
    logic          frozen;
    logic          ready;
    logic          xfer;
    logic          bad;
    logic          accept;
    logic          reject;
    logic          shift_en;
    logic          clr;
    logic [DW-1:0] tap_sel;
    logic          tap_out;
    logic          y_d;

`ifdef DELAY_CTRL_HOLD_EN
    logic          y_q;
    assign hold_w = hold;
`else
    assign hold_w = 1'b0;
`endif

    // Handshake decode; hold only matters once configured
    always_comb begin
        frozen  = hold_w && (state_q != D_IDLE);
        ready   = (state_q != D_FILL) && !frozen;
        xfer    = bus.cfg_valid && ready;
        bad     = bus.cfg_delay > DW'(MAX_DELAY);
        accept  = xfer && !bad;
        reject  = xfer && bad;
        tap_sel = delay_q - DW'(1);
    end

    // Next state, delay, counter and shift controls
    always_comb begin
        state_d   = state_q;
        delay_d   = delay_q;
        cnt_d     = cnt_q;
        cfg_err_d = reject;
        shift_en  = 1'b0;
        clr       = 1'b0;
        if (accept) begin
            delay_d = bus.cfg_delay;
            if (bus.cfg_delay == '0) begin
                state_d = D_RUN;
            end else begin
                clr     = 1'b1;
                cnt_d   = bus.cfg_delay;
                state_d = D_FILL;
            end
        end else if (!frozen) begin
            unique case (state_q)
                D_IDLE: begin
                end
                D_FILL: begin
                    shift_en = 1'b1;
                    cnt_d    = cnt_q - DW'(1);
                    if (cnt_q == DW'(1)) begin
                        state_d = D_RUN;
                    end
                end
                D_RUN: begin
                    shift_en = 1'b1;
                end
                default: state_d = D_IDLE;
            endcase
        end
    end

    // Control registers with asynchronous reset
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= D_IDLE;
            delay_q   <= '0;
            cnt_q     <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            delay_q   <= delay_d;
            cnt_q     <= cnt_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    // Output data: bypass at delay 0, tapped register otherwise
    always_comb begin
        y_d = 1'b0;
        if (state_q == D_RUN) begin
            y_d = (delay_q == '0) ? bus.x : tap_out;
        end
`ifdef DELAY_CTRL_HOLD_EN
        if (frozen) begin
            y_d = y_q;
        end
`endif
    end

`ifdef DELAY_CTRL_HOLD_EN
    // Last driven y, replayed while held
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            y_q <= 1'b0;
        end else begin
            y_q <= y_d;
        end
    end
`endif

    // Status outputs
    always_comb begin
        bus.cfg_ready = ready;
        bus.cfg_err   = cfg_err_q;
        bus.y         = y_d;
        bus.y_valid   = (state_q == D_RUN) && !frozen;
        bus.busy      = (state_q == D_FILL);
    end

    tap_shift_reg #(
        .DEPTH (MAX_DELAY),
        .TW    (DW)
    ) u_sreg (
        .CLK      (CLK),
        .RST      (RST),
        .shift_en (shift_en),
        .clr      (clr),
        .din      (bus.x),
        .tap_sel  (tap_sel),
        .tap_out  (tap_out)
    );

endmodule

// File: tb/tb_delay_ctrl.sv
// Directed testbench for delay_ctrl (default build, MAX_DELAY=16).
// Build option DELAY_CTRL_HOLD_EN: hold is tied low here.
module tb_delay_ctrl;

    logic        CLK;
    logic        RST;
    int          errors;
    int          checks;
    logic [15:0] hist;

    delay_ctrl_if bus ();

`ifdef DELAY_CTRL_HOLD_EN
    logic hold;
    initial hold = 1'b0;
`endif

    delay_ctrl dut (
        .CLK  (CLK),
        .RST  (RST),
`ifdef DELAY_CTRL_HOLD_EN
        .hold (hold),
`endif
        .bus  (bus)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Record the x seen at the coming edge, then step to just after it
    task automatic tick;
        hist = {hist[14:0], bus.x};
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset;
        RST = 1'b1;
        #2;
        checks++;
        if (bus.y !== 1'b0) begin
            errors++; $display("FAIL rst_y got=%b exp=0", bus.y);
        end
        checks++;
        if (bus.y_valid !== 1'b0) begin
            errors++; $display("FAIL rst_yv got=%b exp=0", bus.y_valid);
        end
        checks++;
        if (bus.cfg_ready !== 1'b1) begin
            errors++; $display("FAIL rst_rdy got=%b exp=1", bus.cfg_ready);
        end
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++; $display("FAIL rst_busy got=%b exp=0", bus.busy);
        end
        checks++;
        if (bus.cfg_err !== 1'b0) begin
            errors++; $display("FAIL rst_err got=%b exp=0", bus.cfg_err);
        end
        @(posedge CLK);
        #1;
        RST = 1'b0;
    endtask

    task automatic test_delay3;
        logic [6:0] pat;
        int         busy_n;
        pat    = 7'b1001101;
        busy_n = 0;
        bus.cfg_valid = 1'b1;
        bus.cfg_delay = 5'd3;
        tick();
        bus.cfg_valid = 1'b0;
        for (int k = 0; k < 10; k++) begin
            bus.x = (k < 7) ? pat[k] : 1'b0;
            #2;
            if (bus.busy === 1'b1) busy_n++;
            checks++;
            if (bus.y_valid !== (k >= 3)) begin
                errors++;
                $display("FAIL d3_yv k=%0d got=%b exp=%b", k, bus.y_valid, k >= 3);
            end
            checks++;
            if (bus.cfg_ready !== (k >= 3)) begin
                errors++;
                $display("FAIL d3_rdy k=%0d got=%b exp=%b", k, bus.cfg_ready, k >= 3);
            end
            if (k >= 3) begin
                checks++;
                if (bus.y !== pat[k-3]) begin
                    errors++;
                    $display("FAIL d3_y k=%0d got=%b exp=%b", k, bus.y, pat[k-3]);
                end
            end
            tick();
        end
        checks++;
        if (busy_n != 3) begin
            errors++; $display("FAIL d3_busy_cycles got=%0d exp=3", busy_n);
        end
    endtask

    task automatic test_err_run;
        bus.x = 1'b1;
        bus.cfg_valid = 1'b1;
        bus.cfg_delay = 5'd17;
        #2;
        checks++;
        if (bus.cfg_err !== 1'b0) begin
            errors++; $display("FAIL err_pre got=%b exp=0", bus.cfg_err);
        end
        tick();
        bus.cfg_valid = 1'b0;
        bus.x = 1'b0;
        #2;
        checks++;
        if (bus.cfg_err !== 1'b1) begin
            errors++; $display("FAIL err_pulse got=%b exp=1", bus.cfg_err);
        end
        checks++;
        if (bus.y_valid !== 1'b1 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL err_run yv=%b busy=%b exp 1/0", bus.y_valid, bus.busy);
        end
        checks++;
        if (bus.y !== hist[2]) begin
            errors++; $display("FAIL err_y got=%b exp=%b", bus.y, hist[2]);
        end
        tick();
        bus.x = 1'b1;
        #2;
        checks++;
        if (bus.cfg_err !== 1'b0) begin
            errors++; $display("FAIL err_fall got=%b exp=0", bus.cfg_err);
        end
        checks++;
        if (bus.y !== hist[2] || bus.y_valid !== 1'b1) begin
            errors++;
            $display("FAIL err_keep y=%b yv=%b exp=%b/1", bus.y, bus.y_valid, hist[2]);
        end
        tick();
    endtask

    task automatic test_reconfig;
        int lowv;
        int lowr;
        lowv = 0;
        lowr = 0;
        bus.cfg_valid = 1'b1;
        bus.cfg_delay = 5'd5;
        bus.x = 1'(($urandom_range(0, 1)));
        #2;
        checks++;
        if (bus.cfg_ready !== 1'b1) begin
            errors++; $display("FAIL rc_rdy0 got=%b exp=1", bus.cfg_ready);
        end
        tick();
        bus.cfg_delay = 5'd2;
        for (int k = 0; k < 5; k++) begin
            bus.x = 1'(($urandom_range(0, 1)));
            #2;
            if (bus.y_valid === 1'b0) lowv++;
            if (bus.cfg_ready === 1'b0) lowr++;
            checks++;
            if (bus.busy !== 1'b1) begin
                errors++; $display("FAIL rc_busy k=%0d got=%b exp=1", k, bus.busy);
            end
            tick();
        end
        #2;
        checks++;
        if (lowv != 5 || lowr != 5) begin
            errors++;
            $display("FAIL rc_low_cycles yv=%0d rdy=%0d exp=5/5", lowv, lowr);
        end
        checks++;
        if (bus.y_valid !== 1'b1 || bus.cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL rc_run yv=%b rdy=%b exp=1/1", bus.y_valid, bus.cfg_ready);
        end
        checks++;
        if (bus.y !== hist[4]) begin
            errors++; $display("FAIL rc_y5 got=%b exp=%b", bus.y, hist[4]);
        end
        tick();
        bus.cfg_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            bus.x = 1'(($urandom_range(0, 1)));
            #2;
            checks++;
            if (bus.y_valid !== 1'b0 || bus.busy !== 1'b1) begin
                errors++;
                $display("FAIL rc_refill k=%0d yv=%b busy=%b exp 0/1", k, bus.y_valid, bus.busy);
            end
            tick();
        end
        #2;
        checks++;
        if (bus.y_valid !== 1'b1 || bus.y !== hist[1]) begin
            errors++;
            $display("FAIL rc_y2 yv=%b y=%b exp=1/%b", bus.y_valid, bus.y, hist[1]);
        end
        tick();
    endtask

    task automatic test_zero;
        bus.cfg_valid = 1'b1;
        bus.cfg_delay = 5'd0;
        tick();
        bus.cfg_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            bus.x = k[0];
            #1;
            checks++;
            if (bus.y_valid !== 1'b1 || bus.y !== bus.x) begin
                errors++;
                $display("FAIL z_a k=%0d yv=%b y=%b exp=1/%b", k, bus.y_valid, bus.y, bus.x);
            end
            bus.x = ~k[0];
            #1;
            checks++;
            if (bus.y !== ~k[0]) begin
                errors++; $display("FAIL z_b k=%0d got=%b exp=%b", k, bus.y, ~k[0]);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid_fill;
        bus.cfg_valid = 1'b1;
        bus.cfg_delay = 5'd4;
        bus.x = 1'b1;
        tick();
        bus.cfg_valid = 1'b0;
        tick();
        tick();
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++; $display("FAIL mf_busy got=%b exp=1", bus.busy);
        end
        #1;
        RST = 1'b1;
        #1;
        checks++;
        if (bus.y !== 1'b0 || bus.y_valid !== 1'b0) begin
            errors++; $display("FAIL mf_rst_y y=%b yv=%b exp=0/0", bus.y, bus.y_valid);
        end
        checks++;
        if (bus.cfg_ready !== 1'b1 || bus.busy !== 1'b0 || bus.cfg_err !== 1'b0) begin
            errors++;
            $display("FAIL mf_rst_st rdy=%b busy=%b err=%b exp=1/0/0",
                     bus.cfg_ready, bus.busy, bus.cfg_err);
        end
        RST = 1'b0;
        #1;
        bus.cfg_valid = 1'b1;
        bus.cfg_delay = 5'd20;
        tick();
        bus.cfg_valid = 1'b0;
        #2;
        checks++;
        if (bus.cfg_err !== 1'b1 || bus.busy !== 1'b0 || bus.y_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_err err=%b busy=%b yv=%b exp=1/0/0",
                     bus.cfg_err, bus.busy, bus.y_valid);
        end
        tick();
        #2;
        checks++;
        if (bus.cfg_err !== 1'b0) begin
            errors++; $display("FAIL idle_err_fall got=%b exp=0", bus.cfg_err);
        end
        bus.cfg_valid = 1'b1;
        bus.cfg_delay = 5'd2;
        bus.x = 1'b1;
        tick();
        bus.cfg_valid = 1'b0;
        bus.x = 1'b0;
        #2;
        checks++;
        if (bus.y_valid !== 1'b0 || bus.y !== 1'b0) begin
            errors++; $display("FAIL rf_c0 yv=%b y=%b exp=0/0", bus.y_valid, bus.y);
        end
        tick();
        bus.x = 1'b1;
        tick();
        #2;
        checks++;
        if (bus.y_valid !== 1'b1 || bus.y !== 1'b0) begin
            errors++; $display("FAIL rf_c2 yv=%b y=%b exp=1/0", bus.y_valid, bus.y);
        end
        tick();
        #2;
        checks++;
        if (bus.y !== 1'b1) begin
            errors++; $display("FAIL rf_c3 got=%b exp=1", bus.y);
        end
    endtask

    initial begin
        errors        = 0;
        checks        = 0;
        hist          = '0;
        bus.cfg_valid = 1'b0;
        bus.cfg_delay = '0;
        bus.x         = 1'b0;
        test_reset();
        test_delay3();
        test_err_run();
        test_reconfig();
        test_zero();
        test_reset_mid_fill();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/delay_ctrl.md
# delay_ctrl

Runtime-configurable delay-line controller for bitstream alignment. It accepts a delay value through a valid/ready handshake, flushes and refills an internal variable-tap shift register, and flags when the delayed output stream is valid. It sits in front of stochastic operators whose two operand streams reach the operator with different pipeline depths. It replaces fixed compile-time delays where the alignment depends on the configuration.

## Interface
- MAX_DELAY, 16: largest accepted delay in cycles (≥1).
- DW, $clog2(MAX_DELAY+1): width of the delay field.
- CLK  input  1  clock; all state updates on posedge.
- RST  input  1  asynchronous, active-high reset.
- cfg_valid  input  1  a delay configuration is offered.
- cfg_delay  input  DW  requested delay in cycles.
- cfg_ready  output  1  controller can accept a configuration.
- cfg_err  output  1  one-cycle pulse when an offered delay exceeds MAX_DELAY.
- x  input  1  input bitstream.
- y  output  1  delayed bitstream.
- y_valid  output  1  y carries correctly delayed data.
- busy  output  1  high while in FILL.
- hold  input  1  present only with DELAY_CTRL_HOLD_EN (see Configuration).

## Operation
- **States** (delay_state_t)
  - IDLE: unconfigured; the shift register does not shift.
  - FILL: the register shifts; counter is running.
  - RUN: the register shifts; the output is valid.
- **Reset** (asynchronous, any state): state=IDLE, delay register=0, shift register cleared, counter=0. Outputs: y=0, y_valid=0, cfg_ready=1, cfg_err=0, busy=0.
- **cfg_ready**: equals 1 in IDLE and RUN, 0 in FILL. A transfer occurs at a posedge where cfg_valid && cfg_ready.
- **Rejected transfer** (cfg_delay > MAX_DELAY):
  - cfg_err=1 for the following cycle only.
  - State, delay register and shift register are unchanged.
- **Accepted transfer, cfg_delay=0**:
  - Next state RUN, delay register=0.
  - In RUN with delay 0: y=x combinationally and y_valid=1.
- **Accepted transfer, cfg_delay=d≥1**:
  - Latch d, clear the shift register, load counter=d, next state FILL.
  - The x present in the acceptance cycle is discarded.
- **FILL**:
  - Each edge: shift in x and decrement the counter.
  - When the counter reaches 0, move to RUN on that same edge.
  - y=0, y_valid=0 throughout.
- **RUN, d≥1**: y=sreg[d-1], y_valid=1, shifts every cycle.
- **Reconfiguration in RUN**:
  - Accepted immediately; same rules as from IDLE.
  - y_valid falls on the acceptance edge.
- **cfg_valid during FILL**: not accepted. The requester holds cfg_valid and cfg_delay until cfg_ready returns.
- **Counter width**: DW; it never wraps, because d ≤ MAX_DELAY is enforced.

## Timing
- Acceptance edge E0; cycle 0 follows E0.
- x from cycle 0 is sampled at E1, and d samples are taken at E1..Ed.
- After Ed: y_valid=1 and y=x(cycle 0). Latency is exactly d cycles.
- busy=1 from after E0 through Ed; cfg_ready=0 over the same span.
- Delay 0: y_valid=1 from the cycle after E0, with zero latency.
- cfg_err is registered: it rises after the rejecting edge and falls after the next edge.
- RST assertion mid-FILL or mid-RUN: outputs take their reset values immediately (asynchronous), not on a clock edge.

## Configuration
- Macro: DELAY_CTRL_HOLD_EN.
- **Defined**: adds the hold input. While hold=1 in FILL or RUN:
  - shift register, counter and state are frozen;
  - y keeps its last value;
  - y_valid=0 for that cycle;
  - cfg_ready=0, so no configuration is accepted.
- **hold in IDLE**: has no effect.
- **Undefined**: no hold port; the datapath advances every cycle.

## Structure
- **Package delay_ctrl_pkg**:
  - delay_state_t enum {D_IDLE, D_FILL, D_RUN};
  - localparam helper function computing DW from MAX_DELAY.
- **Sub-module tap_shift_reg**, parameterised by depth MAX_DELAY:
  - ports: shift enable, synchronous clear, serial input, tap select, tapped output;
  - instanced once.
- The FSM, counter and handshake stay in delay_ctrl.

## Test plan
- RST pulse in any state → y=0, y_valid=0, cfg_ready=1, busy=0, cfg_err=0, all without a clock edge.
- Configure 3, then drive x=1,0,1,1,0,0,1 → y_valid high after the 3rd edge; y reproduces 1,0,1,1,0,0,1 shifted by 3 cycles; busy high exactly 3 cycles.
- Configure 0 → from the next cycle y_valid=1 and y tracks x in the same cycle.
- Offer 17 with MAX_DELAY=16 → cfg_err pulses for 1 cycle; prior state and delay are unchanged; y_valid is undisturbed in RUN.
- In RUN at delay 3, configure 5 while holding a second cfg_valid(2) → y_valid is low 5 cycles and cfg_ready is low 5 cycles; the 2 is accepted on the first cycle after the fill, followed by a 2-cycle refill.
- Assert RST mid-FILL (counter=2) → immediate IDLE, y_valid=0; after release, a new configuration refills from a cleared register.
